// File: rtl/cmp_msb_iter_if.sv
// Request/response bundle for cmp_msb_iter: start/busy/done handshake,
// operands, condition select and the registered compare results.
interface cmp_msb_iter_if #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
);
    localparam int PW = $clog2(WIDTH);

    logic             start;
    logic [WIDTH-1:0] rs;
    logic [WIDTH-1:0] rt;
    logic [2:0]       b_type;
    logic             busy;
    logic             done;
    logic             result;
    logic             zero;
    logic [PW-1:0]    rs_msb;
    logic [PW-1:0]    rt_msb;

    // Requester side (hazard unit / decode stage)
    modport master (
        output start, rs, rt, b_type,
        input  busy, done, result, zero, rs_msb, rt_msb
    );

    // Comparator side
    modport slave (
        input  start, rs, rt, b_type,
        output busy, done, result, zero, rs_msb, rt_msb
    );
endinterface

// File: rtl/cmp_msb_iter.sv
// cmp_msb_iter: iterative MSB-position comparator with branch-condition
// evaluation. Scans STEP bits per cycle of both operands from the top down.
// Optional feature macro: CMP_EARLY_EXIT_EN -- leave SCAN as soon as both
// operands have had their highest set bit located.
module cmp_msb_iter #(
    parameter int WIDTH = 32,
    parameter int STEP  = 4
) (
    input  logic           i_clk,
    input  logic           i_reset,
    cmp_msb_iter_if.slave  bus
);
    localparam int NCHUNK = WIDTH / STEP;
    localparam int PW     = $clog2(WIDTH);
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_rs, r_rt;
    logic [2:0]       r_btype;
    logic [CW-1:0]    r_cursor;
    logic             r_rs_found, r_rt_found;
    logic [PW-1:0]    r_rs_idx, r_rt_idx;
    logic             r_result, r_zero;
    logic [PW-1:0]    r_rs_msb, r_rt_msb;

    logic             w_accept, w_exit;
    logic [STEP-1:0]  w_rs_chunk, w_rt_chunk;
    logic             w_rs_hit, w_rt_hit;
    logic [PW-1:0]    w_rs_pos, w_rt_pos;
    logic             w_rs_found_nxt, w_rt_found_nxt;
    logic [PW-1:0]    w_rs_idx_nxt, w_rt_idx_nxt;
    logic             w_result, w_zero;

    assign w_accept   = bus.start && (r_state == IDLE || r_state == DONE);
    assign w_rs_chunk = r_rs[int'(r_cursor)*STEP +: STEP];
    assign w_rt_chunk = r_rt[int'(r_cursor)*STEP +: STEP];

    // Highest set bit in the current chunk of each operand (last hit wins)
    always_comb begin
        w_rs_hit = 1'b0;
        w_rt_hit = 1'b0;
        w_rs_pos = '0;
        w_rt_pos = '0;
        for (int j = 0; j < STEP; j++) begin
            if (w_rs_chunk[j]) begin
                w_rs_hit = 1'b1;
                w_rs_pos = PW'(int'(r_cursor) * STEP + j);
            end
            if (w_rt_chunk[j]) begin
                w_rt_hit = 1'b1;
                w_rt_pos = PW'(int'(r_cursor) * STEP + j);
            end
        end
    end

    // Found state after this cycle's chunk; the first hit from the top sticks
    always_comb begin
        w_rs_found_nxt = r_rs_found || w_rs_hit;
        w_rt_found_nxt = r_rt_found || w_rt_hit;
        w_rs_idx_nxt   = r_rs_found ? r_rs_idx : (w_rs_hit ? w_rs_pos : '0);
        w_rt_idx_nxt   = r_rt_found ? r_rt_idx : (w_rt_hit ? w_rt_pos : '0);
    end

    // Compare result and branch condition from the latched operands
    always_comb begin
        w_result = w_rs_found_nxt && w_rt_found_nxt && (w_rs_idx_nxt == w_rt_idx_nxt);
        w_zero   = 1'b0;
        case (r_btype)
            3'd0:    w_zero = (r_rs == r_rt);
            3'd1:    w_zero = (r_rs != r_rt);
            3'd2:    w_zero = ($signed(r_rs) <= 0);
            3'd3:    w_zero = ($signed(r_rs) >  0);
            3'd4:    w_zero = ($signed(r_rs) <  0);
            3'd5:    w_zero = ($signed(r_rs) >= 0);
            3'd6:    w_zero = w_result;
            default: w_zero = 1'b0;
        endcase
    end

`ifdef CMP_EARLY_EXIT_EN
    // Stop once both MSBs are located; zero operands still need the full scan
    assign w_exit = (r_cursor == '0) || (w_rs_found_nxt && w_rt_found_nxt);
`else
    assign w_exit = (r_cursor == '0);
`endif

    // FSM state register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // FSM next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = SCAN;
            SCAN:    if (w_exit)    w_state_nxt = DONE;
            DONE:    w_state_nxt = bus.start ? SCAN : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand latch, scan progress and result registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rs       <= '0;
            r_rt       <= '0;
            r_btype    <= '0;
            r_cursor   <= '0;
            r_rs_found <= 1'b0;
            r_rt_found <= 1'b0;
            r_rs_idx   <= '0;
            r_rt_idx   <= '0;
            r_result   <= 1'b0;
            r_zero     <= 1'b0;
            r_rs_msb   <= '0;
            r_rt_msb   <= '0;
        end else if (w_accept) begin
            r_rs       <= bus.rs;
            r_rt       <= bus.rt;
            r_btype    <= bus.b_type;
            r_cursor   <= CW'(NCHUNK - 1);
            r_rs_found <= 1'b0;
            r_rt_found <= 1'b0;
            r_rs_idx   <= '0;
            r_rt_idx   <= '0;
        end else if (r_state == SCAN) begin
            r_rs_found <= w_rs_found_nxt;
            r_rt_found <= w_rt_found_nxt;
            r_rs_idx   <= w_rs_idx_nxt;
            r_rt_idx   <= w_rt_idx_nxt;
            r_cursor   <= r_cursor - 1'b1;
            if (w_exit) begin
                r_result <= w_result;
                r_zero   <= w_zero;
                r_rs_msb <= w_rs_idx_nxt;
                r_rt_msb <= w_rt_idx_nxt;
            end
        end
    end

    assign bus.busy   = (r_state == SCAN);
    assign bus.done   = (r_state == DONE);
    assign bus.result = r_result;
    assign bus.zero   = r_zero;
    assign bus.rs_msb = r_rs_msb;
    assign bus.rt_msb = r_rt_msb;
endmodule

// File: doc/cmp_msb_iter.md
# cmp_msb_iter

Iterative, parametrised successor to the decode-stage comparator. It computes the highest-set-bit position of two operands by scanning STEP bits per cycle from the MSB down. It also evaluates an extended branch-condition set. A start/busy/done handshake lets the hazard unit stall D while a compare is in flight, the same way the MDU stall works.

## Interface
- WIDTH, 32, operand width; must be a multiple of STEP.
- STEP, 4, bits scanned per cycle per operand; must be ≥1 and divide WIDTH.
- Derived constants: NCHUNK = WIDTH/STEP; PW = $clog2(WIDTH).
- clk  in  1  single clock, rising edge; synchronous, active-high reset.
- reset  in  1  synchronous, active-high; sampled only on rising clk.
- start  in  1  request; accepted only in IDLE or DONE.
- rs  in  WIDTH  operand A; sampled on the accepting edge.
- rt  in  WIDTH  operand B; sampled on the accepting edge.
- b_type  in  3  condition select; sampled on the accepting edge.
- busy  out  1  high in SCAN.
- done  out  1  one-cycle pulse; high exactly while the FSM is in DONE.
- result  out  1  1 iff rs≠0, rt≠0 and rs_msb==rt_msb.
- zero  out  1  branch-condition outcome for the latched b_type.
- rs_msb  out  PW  index of highest 1 in rs; 0 if rs==0.
- rt_msb  out  PW  index of highest 1 in rt; 0 if rt==0.

## Operation
- FSM states: IDLE, SCAN, DONE. Reset drives the FSM to IDLE.
- Reset also clears every output to 0, plus the internal found flags and the cursor.
- IDLE/DONE with start=1: latch rs, rt and b_type, set cursor=NCHUNK-1, clear the found flags, go to SCAN.
- DONE with start=0: go to IDLE.
- SCAN, each cycle: examine bits [cursor*STEP+STEP-1 : cursor*STEP] of each latched operand.
  - For an operand not yet found, if the chunk contains a 1, record the index of the highest 1 in the chunk and set its found flag.
  - Then decrement the cursor.
- SCAN exit: go to DONE after the chunk with cursor==0. Early exit is governed by Configuration.
- On entering DONE, these outputs are registered and held until the next accepted start or reset: result, rs_msb, rt_msb, zero.
- zero by latched b_type:
  - 0: rs==rt
  - 1: rs!=rt
  - 2: signed rs≤0
  - 3: signed rs>0
  - 4: signed rs<0
  - 5: signed rs≥0
  - 6: same as result
  - 7: 0
- start while in SCAN is ignored; no queueing.
- Operand or b_type changes after the accepting edge have no effect.

## Timing
- Accepting edge E0. Chunk k (0 = top) is evaluated at edge E(k+1).
- done rises after the last evaluated chunk's edge and stays high exactly one cycle.
- Fixed latency: NCHUNK SCAN cycles, so done is high in the cycle after edge E(NCHUNK).
- busy is high from the cycle after E0 through the last SCAN cycle. busy and done are never high together.
- Back-to-back: start high during the done cycle is accepted; the next cycle is SCAN and busy=1.
- Reset asserted during SCAN: next cycle is IDLE, busy=0, done=0, outputs=0. The partial compare is discarded.
- Reset and start in the same cycle: reset wins.

## Configuration
- CMP_EARLY_EXIT_EN defined:
  - SCAN goes to DONE on the first edge where both found flags are set.
  - If either operand is zero, the full NCHUNK cycles still run.
  - Latency = max(chunk index of the two MSBs)+1 SCAN cycles.
- CMP_EARLY_EXIT_EN undefined: always NCHUNK SCAN cycles. Outputs are identical; only timing differs.

## Test plan
- WIDTH=32, STEP=4, rs=0x00F00000, rt=0x00800001, b_type=6, start:
  - outputs: rs_msb=23, rt_msb=23, result=1, zero=1.
  - with CMP_EARLY_EXIT_EN, done after 3 SCAN cycles; without it, after 8.
- rs=0, rt=0x00000010, b_type=0:
  - outputs: result=0, rs_msb=0, rt_msb=4, zero=0.
  - 8 SCAN cycles in both builds.
- rs=rt=0x80000000, b_type=2:
  - outputs: zero=1, result=1, msb=31.
  - early-exit build finishes after 1 SCAN cycle.
- Start pulse during SCAN with different operands: ignored; the first compare's results and cycle count are unchanged. Start asserted during the done cycle launches the second compare immediately.
- Reset asserted on SCAN cycle 2: next cycle busy=0, done=0 and all outputs=0. A following start with rs=0x1, rt=0x3, b_type=1 yields zero=1, result=0, rs_msb=0, rt_msb=1.
